// File: rtl/lsb_stream_extractor.sv
// -----------------------------------------------------------------------------
// lsb_stream_extractor
//
// Streaming LSB-steganography decoder. Each accepted pixel word carries
// PIX_BYTES bytes. The LSB_N least-significant bits of every byte are packed
// into a bitstream, least significant first. The bitstream is then emitted as
// K = PIX_BYTES*LSB_N/8 message bytes, lowest byte first. A message terminates
// on the DELIM byte. The terminator itself is never emitted.
//
// Optional feature macro: DELIM_DETECT_EN
//   defined     : delimiter compare is active. On a delimiter the block parks
//                 in DONE until clear/rst.
//   not defined : there is no compare, DONE is unreachable and done is tied
//                 low. Every byte is emitted, including DELIM values.
//
// Parameters
//   PIX_BYTES  bytes per input word; PIX_BYTES*LSB_N must be a multiple of 8
//   LSB_N      LSBs taken per byte (1..4)
//   DELIM      terminator byte
//   CNT_W      width of byte_count
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   clear       synchronous restart to IDLE; overrides every handshake
//   in_valid    input word valid
//   in_ready    input word accepted when in_valid && in_ready
//   in_pixel    packed pixel word, byte j = in_pixel[8j +: 8]
//   out_valid   message byte valid
//   out_ready   sink accepts byte when out_valid && out_ready
//   out_byte    message byte
//   done        delimiter seen; held until clear/rst
//   byte_count  bytes emitted since rst/clear, saturating
//   dbg_state   current FSM state (IDLE=0, EMIT=1, DONE=2)
//
// Handshake rule (both ports): a transfer happens on a rising clk edge where
// valid && ready are both high. Once raised, out_valid stays high and out_byte
// stays stable until that transfer. The only exceptions are clear and rst,
// which drop the pending byte.
// -----------------------------------------------------------------------------
module lsb_stream_extractor #(
  parameter int         PIX_BYTES = 8,
  parameter int         LSB_N     = 1,
  parameter logic [7:0] DELIM     = 8'd36,
  parameter int         CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*PIX_BYTES-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_byte,
  output logic                   done,
  output logic [CNT_W-1:0]       byte_count,
  output logic [1:0]             dbg_state
);

  localparam int BITS  = PIX_BYTES * LSB_N;
  localparam int K     = BITS / 8;
  localparam int IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [BITS-1:0]  word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [BITS-1:0]  in_bits;
  logic [7:0]       cur_byte;
  logic             is_delim;
  logic             load;
  logic             in_ready_c;

  // Gather the LSB_N low bits of each pixel byte into one contiguous bitstream.
  // The upper bits of each pixel byte carry no message data.
  for (genvar j = 0; j < PIX_BYTES; j++) begin : g_gather
    assign in_bits[LSB_N*j +: LSB_N] = in_pixel[8*j +: LSB_N];
  end

  logic unused_pix_bits;
  assign unused_pix_bits = ^in_pixel;

  // Byte currently presented from the registered bitstream.
  if (K == 1) begin : g_one_byte
    assign cur_byte = word_q[7:0];
  end else begin : g_multi_byte
    assign cur_byte = word_q[{idx_q, 3'b000} +: 8];
  end

`ifdef DELIM_DETECT_EN
  assign is_delim = (cur_byte == DELIM);
`else
  logic [7:0] unused_delim;
  assign unused_delim = DELIM;
  assign is_delim     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    cnt_d      = cnt_q;
    in_ready_c = 1'b0;
    out_valid  = 1'b0;
    load       = 1'b0;

    if (clear) begin
      // The restart wins over both handshakes. A pending byte is dropped and
      // no word is taken this cycle.
      state_d = S_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          in_ready_c = 1'b1;
          load       = in_valid;
        end

        S_EMIT: begin
          if (is_delim) begin
            // The terminator is swallowed. The rest of this word is discarded.
            state_d = S_DONE;
          end else begin
            out_valid = 1'b1;
            if (out_ready) begin
              if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
              end
              if (idx_q == LAST_IDX) begin
                // The last byte is leaving, so the next word can load straight
                // into EMIT with no idle bubble.
                in_ready_c = 1'b1;
                if (in_valid) begin
                  load = 1'b1;
                end else begin
                  state_d = S_IDLE;
                end
              end else begin
                idx_d = idx_q + 1'b1;
              end
            end
          end
        end

        S_DONE: begin
          state_d = S_DONE;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (load) begin
      word_d  = in_bits;
      idx_d   = '0;
      state_d = S_EMIT;
    end
  end

  // While reset is held the state register already reads IDLE. Nothing may be
  // accepted during that time, so in_ready is masked by rst.
  assign in_ready = in_ready_c & ~rst;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_byte   = cur_byte;
  assign byte_count = cnt_q;
  assign dbg_state  = state_q;

`ifdef DELIM_DETECT_EN
  assign done = (state_q == S_DONE);
`else
  assign done = 1'b0;
`endif

endmodule
